cpu_mem_xfer: RTL and testbench
===============================

CPU_MEM_XFER -- requirements
Module: cpu_mem_xfer

Interface
REQ-001 SHALL have parameter PROTECT_LIMIT, default 12'h200, meaning writes to addresses below this value are flagged as protected.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request strobe; accepted only when busy=0.
REQ-005 SHALL have port op  in  2  operation code: 00 STORE (FX55), 01 LOAD (FX65), 10 BCD (FX33), 11 reserved.
REQ-006 SHALL have port x  in  4  highest register index to transfer.
REQ-007 SHALL have port base_i  in  12  base memory address (I).
REQ-008 SHALL have port bcd_val  in  8  value to convert for BCD.
REQ-009 SHALL have port busy  out  1  operation in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port err  out  1  error flag, valid only while done=1.
REQ-012 SHALL have port i_next  out  12  updated I value, valid while done=1.
REQ-013 SHALL have port mem_en  out  1  memory port enable.
REQ-014 SHALL have port mem_write  out  1  memory write strobe.
REQ-015 SHALL have port mem_addr  out  12  memory address.
REQ-016 SHALL have port mem_wdata  out  8  memory write data.
REQ-017 SHALL have port mem_rdata  in  8  memory read data, registered, valid one cycle after a read.
REQ-018 SHALL have port reg_idx  out  4  register-file index, used for both read and write.
REQ-019 SHALL have port reg_rdata  in  8  combinational register-file read data for reg_idx.
REQ-020 SHALL have port reg_we  out  1  register-file write enable.
REQ-021 SHALL have port reg_wdata  out  8  register-file write data.

Function
REQ-022 SHALL latch op, x, base_i and bcd_val in the cycle start is accepted; later input changes have no effect on the operation in progress.
REQ-023 SHALL use states IDLE, STORE, LOAD, LOAD_LAST, BCD and DONE; a start while busy=1 SHALL be ignored.
REQ-024 SHALL hold busy=1 in every state except IDLE and DONE; DONE SHALL last exactly one cycle with done=1, then return to IDLE unless a new start is accepted in that cycle.
REQ-025 STORE: for k=0..x, one per cycle, SHALL drive reg_idx=k, mem_en=1, mem_write=1, mem_addr=base_i+k, mem_wdata=reg_rdata; DONE SHALL follow the last write; i_next=base_i+x+1.
REQ-026 LOAD: in cycle k (k=0..x) SHALL issue a read with mem_en=1, mem_write=0, mem_addr=base_i+k.
REQ-027 LOAD: in cycle k+1 SHALL drive reg_we=1, reg_idx=k, reg_wdata=mem_rdata; reads and register writes overlap, so the operation takes x+2 busy cycles, and LOAD_LAST performs the final register write only.
REQ-028 LOAD: i_next SHALL equal base_i+x+1.
REQ-029 BCD: SHALL write hundreds, tens and ones digits of bcd_val, each 0-9, to base_i, base_i+1 and base_i+2 in 3 consecutive cycles; i_next SHALL equal base_i.
REQ-030 All address arithmetic SHALL be 12-bit modulo 4096; 12'hFFF+1 wraps to 12'h000.
REQ-031 If any write address is below PROTECT_LIMIT, the write SHALL still be issued, and err SHALL be 1 at done; the error flag is sticky per operation and cleared on accept.
REQ-032 op=11 SHALL produce no memory or register access; DONE with err=1 SHALL follow in the next cycle; i_next=base_i.
REQ-033 Outside active access cycles, mem_en, mem_write and reg_we SHALL be 0.

Reset
REQ-034 On rst_n=0, the block SHALL immediately enter IDLE, with busy, done, err, mem_en, mem_write and reg_we at 0, and mem_addr, mem_wdata, reg_idx, reg_wdata and i_next at 0.
REQ-035 Reset asserted mid-operation SHALL abort it with no further accesses and no done pulse.

Verification
REQ-036 STORE: x=2, base_i=0x300, V0..V2=11,22,33 -> writes 0x300=11, 0x301=22, 0x302=33 on 3 cycles, done one cycle later, err=0, i_next=0x303.
REQ-037 LOAD: x=3, base_i=0x400, mem=A0..A3 -> reg writes V0..V3=A0..A3 lagging reads by 1 cycle, 5 busy cycles, i_next=0x404.
REQ-038 BCD: bcd_val=254, base_i=0x500 -> 0x500=2, 0x501=5, 0x502=4, i_next=0x500, err=0.
REQ-039 Boundaries: STORE with x=1, base_i=0xFFF -> addresses 0xFFF then 0x000, err=1, i_next=0x001; op=11 -> done and err=1 the next cycle, no accesses.
REQ-040 Protocol: start pulsed while busy -> ignored; rst_n low in the 2nd cycle of a LOAD with x=5 -> all outputs 0, no done; a new start after release works normally.

Source files
------------

// File: rtl/cpu_mem_xfer.sv
// Bulk register/memory transfer engine for a CHIP-8 style core.
// Handles FX55 (store V0..VX to [I]), FX65 (load V0..VX from [I]) and
// FX33 (BCD of a value to [I..I+2]). Memory and register-file accesses
// are decoded combinationally from the FSM state and the beat counter.
module cpu_mem_xfer #(
    parameter logic [11:0] PROTECT_LIMIT = 12'h200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [3:0]  x,
    input  logic [11:0] base_i,
    input  logic [7:0]  bcd_val,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [11:0] i_next,
    output logic        mem_en,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [3:0]  reg_idx,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [7:0]  reg_wdata
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] STORE     = 3'd1;
    localparam logic [2:0] LOAD      = 3'd2;
    localparam logic [2:0] LOAD_LAST = 3'd3;
    localparam logic [2:0] BCD       = 3'd4;
    localparam logic [2:0] DONE      = 3'd5;

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_BCD   = 2'b10;

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic [3:0]  x_r;
    logic [11:0] base_r;
    logic [7:0]  bcd_r;
    logic        err_r;
    logic [11:0] i_next_r;
    logic        accept;
    logic [11:0] addr;
    logic        protect_hit;

    // Decimal digit of an 8-bit value: pos 0 = hundreds, 1 = tens, 2 = ones.
    function automatic logic [7:0] bcd_digit(input logic [7:0] val, input logic [1:0] pos);
        logic [7:0] d;
        case (pos)
            2'd0:    d = val / 8'd100;
            2'd1:    d = (val / 8'd10) % 8'd10;
            default: d = val % 8'd10;
        endcase
        return d;
    endfunction

    // A new request is taken in IDLE and also in the single DONE cycle.
    assign accept = start && ((state == IDLE) || (state == DONE));

    // Current beat address; the 12-bit sum wraps naturally at 4096.
    assign addr = base_r + {8'd0, cnt};

    assign busy   = (state != IDLE) && (state != DONE);
    assign done   = (state == DONE);
    assign err    = (state == DONE) ? err_r : 1'b0;
    assign i_next = i_next_r;

    // Access decode: every strobe and bus is zero unless this state owns it.
    always_comb begin
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 12'd0;
        mem_wdata = 8'd0;
        reg_idx   = 4'd0;
        reg_we    = 1'b0;
        reg_wdata = 8'd0;
        case (state)
            STORE: begin
                mem_en    = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr;
                reg_idx   = cnt;
                mem_wdata = reg_rdata;
            end
            LOAD: begin
                mem_en   = 1'b1;
                mem_addr = addr;
                // Read data from the previous beat lands in the register file now.
                if (cnt != 4'd0) begin
                    reg_we    = 1'b1;
                    reg_idx   = cnt - 4'd1;
                    reg_wdata = mem_rdata;
                end
            end
            LOAD_LAST: begin
                reg_we    = 1'b1;
                reg_idx   = x_r;
                reg_wdata = mem_rdata;
            end
            BCD: begin
                mem_en    = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr;
                mem_wdata = bcd_digit(bcd_r, cnt[1:0]);
            end
            default: ;
        endcase
    end

    assign protect_hit = mem_write && (mem_addr < PROTECT_LIMIT);

    // Operand capture on accept; these are pure data and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_r    <= x;
            base_r <= base_i;
            bcd_r  <= bcd_val;
        end
    end

    // Control FSM, beat counter, sticky error and updated I pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            err_r    <= 1'b0;
            i_next_r <= 12'd0;
        end else if (accept) begin
            cnt <= 4'd0;
            case (op)
                OP_STORE: begin
                    state    <= STORE;
                    err_r    <= 1'b0;
                    i_next_r <= base_i + {8'd0, x} + 12'd1;
                end
                OP_LOAD: begin
                    state    <= LOAD;
                    err_r    <= 1'b0;
                    i_next_r <= base_i + {8'd0, x} + 12'd1;
                end
                OP_BCD: begin
                    state    <= BCD;
                    err_r    <= 1'b0;
                    i_next_r <= base_i;
                end
                default: begin
                    // Reserved opcode: no access, report an error right away.
                    state    <= DONE;
                    err_r    <= 1'b1;
                    i_next_r <= base_i;
                end
            endcase
        end else begin
            case (state)
                STORE: begin
                    err_r <= err_r | protect_hit;
                    if (cnt == x_r) state <= DONE;
                    else            cnt   <= cnt + 4'd1;
                end
                LOAD: begin
                    if (cnt == x_r) state <= LOAD_LAST;
                    else            cnt   <= cnt + 4'd1;
                end
                LOAD_LAST: state <= DONE;
                BCD: begin
                    err_r <= err_r | protect_hit;
                    if (cnt == 4'd2) state <= DONE;
                    else             cnt   <= cnt + 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_xfer.sv
// Self-checking bench for cpu_mem_xfer: behavioural memory and register
// file, a directed vector table, and hand-written multi-cycle sequences.
module tb_cpu_mem_xfer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  x;
    logic [11:0] base_i;
    logic [7:0]  bcd_val;
    logic        busy, done, err;
    logic [11:0] i_next;
    logic        mem_en, mem_write;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [3:0]  reg_idx;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [7:0]  reg_wdata;

    cpu_mem_xfer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x),
        .base_i(base_i), .bcd_val(bcd_val), .busy(busy), .done(done),
        .err(err), .i_next(i_next), .mem_en(mem_en), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .reg_idx(reg_idx), .reg_rdata(reg_rdata), .reg_we(reg_we),
        .reg_wdata(reg_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } acc_t;

    logic [7:0]  mem [4096];
    logic [7:0]  regs [16];
    acc_t        wr_q[$];
    acc_t        rd_q[$];
    acc_t        rw_q[$];
    logic [31:0] cyc = 0;
    int          done_cnt = 0;
    bit          init_done = 1'b0;

    assign reg_rdata = regs[reg_idx];

    // Memory / register-file model with access logging.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 16; i++) regs[i] <= 8'(11 * (i + 1));
            for (int i = 0; i < 4; i++) mem[12'h400 + i] <= 8'hA0 + 8'(i);
            mem[12'h100] <= 8'h5A;
            mem_rdata <= 8'h00;
            init_done <= 1'b1;
        end else begin
            if (mem_en && mem_write) begin
                mem[mem_addr] <= mem_wdata;
                wr_q.push_back({mem_addr, mem_wdata, cyc});
            end
            if (mem_en && !mem_write) begin
                mem_rdata <= mem[mem_addr];
                rd_q.push_back({mem_addr, 8'h00, cyc});
            end
            if (reg_we) begin
                regs[reg_idx] <= reg_wdata;
                rw_q.push_back({8'h00, reg_idx, reg_wdata, cyc});
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, optionally poke a second start while busy, and wait
    // (bounded) for done. Returns busy-cycle count and done-time results.
    task automatic run_op(input logic [1:0] o, input logic [3:0] xx, input logic [11:0] b,
                          input logic [7:0] v, input bit poke,
                          output int ncyc, output bit seen, output bit e,
                          output logic [11:0] inx, output int nacc, output int nwr);
        int w0, r0, g0;
        @(negedge clk);
        w0 = wr_q.size(); r0 = rd_q.size(); g0 = rw_q.size();
        start = 1'b1; op = o; x = xx; base_i = b; bcd_val = v;
        @(negedge clk);
        start = 1'b0; op = ~o; x = ~xx; base_i = ~b; bcd_val = ~v;
        ncyc = 0; seen = 1'b0; e = 1'b0; inx = 12'h000;
        for (int n = 0; n < 40; n++) begin
            if (done) begin
                seen = 1'b1; e = err; inx = i_next;
                break;
            end
            if (busy) ncyc++;
            if (poke && n == 1) begin
                start = 1'b1; op = 2'b00; x = 4'd0; base_i = 12'h050;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        nwr  = wr_q.size() - w0;
        nacc = nwr + (rd_q.size() - r0) + (rw_q.size() - g0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  x;
        logic [11:0] base;
        logic [7:0]  bcd;
        int          busy;
        bit          err;
        logic [11:0] inext;
        int          acc;
        bit          chk_mem;
        logic [11:0] chk_addr;
        logic [7:0]  chk_data;
    } vec_t;

    vec_t vec[10];

    initial begin
        int ncyc, nacc, nwr, w0, r0, g0, d0;
        bit seen, e;
        logic [11:0] inx;
        logic [7:0] got;

        vec[0] = '{2'b00, 4'd2,  12'h300, 8'd0,   3,  1'b0, 12'h303, 3,  1'b1, 12'h302, 8'd33};
        vec[1] = '{2'b10, 4'd0,  12'h500, 8'd254, 3,  1'b0, 12'h500, 3,  1'b1, 12'h501, 8'd5};
        vec[2] = '{2'b00, 4'd1,  12'hFFF, 8'd0,   2,  1'b1, 12'h001, 2,  1'b1, 12'h000, 8'd22};
        vec[3] = '{2'b11, 4'd4,  12'h123, 8'd0,   0,  1'b1, 12'h123, 0,  1'b1, 12'h300, 8'd11};
        vec[4] = '{2'b10, 4'd7,  12'h1F0, 8'd9,   3,  1'b1, 12'h1F0, 3,  1'b1, 12'h1F2, 8'd9};
        vec[5] = '{2'b00, 4'd0,  12'h1FF, 8'd0,   1,  1'b1, 12'h200, 1,  1'b1, 12'h1FF, 8'd11};
        vec[6] = '{2'b00, 4'd15, 12'h200, 8'd0,   16, 1'b0, 12'h210, 16, 1'b1, 12'h20F, 8'd176};
        vec[7] = '{2'b10, 4'd7,  12'hFFE, 8'd107, 3,  1'b1, 12'hFFE, 3,  1'b1, 12'h000, 8'd7};
        vec[8] = '{2'b01, 4'd3,  12'h400, 8'd0,   5,  1'b0, 12'h404, 8,  1'b0, 12'h003, 8'hA3};
        vec[9] = '{2'b01, 4'd0,  12'h100, 8'd0,   2,  1'b0, 12'h101, 2,  1'b0, 12'h000, 8'h5A};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; x = 4'd0; base_i = 12'h000; bcd_val = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_outputs",
              {done, err, mem_en, mem_write, reg_we, mem_addr, mem_wdata, reg_idx, reg_wdata, i_next},
              0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // STORE V0..V2 to 0x300: consecutive writes with the right addresses and data.
        w0 = wr_q.size();
        run_op(2'b00, 4'd2, 12'h300, 8'd0, 1'b0, ncyc, seen, e, inx, nacc, nwr);
        check("store_done_seen", {31'd0, seen}, 32'd1);
        check("store_busy_cycles", ncyc, 3);
        check("store_err", {31'd0, e}, 32'd0);
        check("store_i_next", {20'd0, inx}, 32'h303);
        for (int k = 0; k < 3; k++) begin
            check("store_trace_addr", {20'd0, wr_q[w0 + k].addr}, 32'h300 + k);
            check("store_trace_data", {24'd0, wr_q[w0 + k].data}, 11 * (k + 1));
            check("store_trace_cycle", wr_q[w0 + k].cyc, wr_q[w0].cyc + k);
        end

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            run_op(vec[i].op, vec[i].x, vec[i].base, vec[i].bcd, 1'b0, ncyc, seen, e, inx, nacc, nwr);
            check($sformatf("vec%0d_done_seen", i), {31'd0, seen}, 32'd1);
            check($sformatf("vec%0d_busy_cycles", i), ncyc, vec[i].busy);
            check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vec[i].err});
            check($sformatf("vec%0d_i_next", i), {20'd0, inx}, {20'd0, vec[i].inext});
            check($sformatf("vec%0d_accesses", i), nacc, vec[i].acc);
            @(negedge clk);
            got = vec[i].chk_mem ? mem[vec[i].chk_addr] : regs[vec[i].chk_addr[3:0]];
            check($sformatf("vec%0d_data", i), {24'd0, got}, {24'd0, vec[i].chk_data});
        end

        // LOAD V0..V3 from 0x400: each register write trails its read by one cycle.
        r0 = rd_q.size(); g0 = rw_q.size();
        run_op(2'b01, 4'd3, 12'h400, 8'd0, 1'b0, ncyc, seen, e, inx, nacc, nwr);
        check("load_busy_cycles", ncyc, 5);
        check("load_i_next", {20'd0, inx}, 32'h404);
        check("load_reads", rd_q.size() - r0, 4);
        check("load_regwrites", rw_q.size() - g0, 4);
        for (int k = 0; k < 4; k++) begin
            check("load_trace_raddr", {20'd0, rd_q[r0 + k].addr}, 32'h400 + k);
            check("load_trace_widx", {20'd0, rw_q[g0 + k].addr}, k);
            check("load_trace_wdata", {24'd0, rw_q[g0 + k].data}, 32'hA0 + k);
            check("load_trace_lag", rw_q[g0 + k].cyc, rd_q[r0 + k].cyc + 1);
        end

        // Start pulsed while busy must not disturb the running LOAD.
        run_op(2'b01, 4'd3, 12'h400, 8'd0, 1'b1, ncyc, seen, e, inx, nacc, nwr);
        check("poke_done_seen", {31'd0, seen}, 32'd1);
        check("poke_busy_cycles", ncyc, 5);
        check("poke_err", {31'd0, e}, 32'd0);
        check("poke_i_next", {20'd0, inx}, 32'h404);
        check("poke_no_writes", nwr, 0);

        // Reset in the 2nd busy cycle of a LOAD x=5 aborts it silently.
        @(negedge clk);
        start = 1'b1; op = 2'b01; x = 4'd5; base_i = 12'h400;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_outputs",
              {done, err, mem_en, mem_write, reg_we, mem_addr, mem_wdata, reg_idx, reg_wdata, i_next},
              0);
        d0 = done_cnt; w0 = wr_q.size(); r0 = rd_q.size(); g0 = rw_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_no_access", (wr_q.size() - w0) + (rd_q.size() - r0) + (rw_q.size() - g0), 0);

        // Normal operation after reset release.
        run_op(2'b10, 4'd0, 12'h500, 8'd254, 1'b0, ncyc, seen, e, inx, nacc, nwr);
        check("post_done_seen", {31'd0, seen}, 32'd1);
        check("post_busy_cycles", ncyc, 3);
        check("post_err", {31'd0, e}, 32'd0);
        check("post_i_next", {20'd0, inx}, 32'h500);
        @(negedge clk);
        check("post_hundreds", {24'd0, mem[12'h500]}, 32'd2);
        check("post_ones", {24'd0, mem[12'h502]}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
